multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_ctrl.sv | 138 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IF/ID/EXE/MEM/WB sequencer driving datapath controls decoded from op/funct.
module multicycle_ctrl #(
  parameter logic [5:0] HALT_OP = 6'b111111,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctrl,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       mem_to_reg,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [2:0] {
    s_if   = 3'd0,
    s_id   = 3'd1,
    s_exe  = 3'd2,
    s_mem  = 3'd3,
    s_wb   = 3'd4,
    s_halt = 3'd5
  } state_t;
  state_t cur, nxt;
  logic r_type, r_ok, legal, is_j, is_jal, is_lw, is_sw, is_beq, is_bne, is_ori, is_slti, taken;
  logic src_a_dec;
  logic [1:0] src_b_dec;
  logic [3:0] alu_dec;
  assign r_type  = op == 6'b000000;
  assign r_ok    = r_type && (funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000});
  assign is_j    = op == 6'b000010;
  assign is_jal  = op == 6'b000011;
  assign is_beq  = op == 6'b000100;
  assign is_bne  = op == 6'b000101;
  assign is_slti = op == 6'b001010;
  assign is_ori  = op == 6'b001101;
  assign is_lw   = op == 6'b100011;
  assign is_sw   = op == 6'b101011;
  assign legal   = r_ok || is_beq || is_bne || is_slti || is_ori || is_lw || is_sw || op == 6'b001000;
  assign taken   = (is_beq && zero) || (is_bne && !zero);
  // ALU decode is shared by EXE and WB so WB holds the EXE operation
  assign src_a_dec = r_type && funct == 6'b000000;
  assign src_b_dec = is_ori ? 2'd2 : (op == 6'b001000 || is_slti || is_lw || is_sw) ? 2'd1 : 2'd0;
  assign alu_dec = r_type ? (funct == 6'b100010 ? 4'd1 :
                             funct == 6'b100100 ? 4'd2 :
                             funct == 6'b100101 ? 4'd3 :
                             funct == 6'b101010 ? 4'd4 :
                             funct == 6'b000000 ? 4'd5 : 4'd0) :
                   is_slti ? 4'd4 : is_ori ? 4'd3 : (is_beq || is_bne) ? 4'd1 : 4'd0;
  assign state = cur;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cur         <= s_if;
      instr_count <= '0;
    end else begin
      cur <= nxt;
      if (pc_write) instr_count <= instr_count + CNT_W'(1);
    end
  always_comb begin
    nxt        = cur;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    reg_dst    = 2'd0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_ctrl   = 4'd0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 2'd0;
    illegal    = 1'b0;
    halted     = 1'b0;
    if (reset_n)
      case (cur)
        s_if: begin
          ir_write = 1'b1;
          nxt      = s_id;
        end
        s_id:
          if (is_j || is_jal) begin
            pc_write   = 1'b1;
            pc_src     = 2'd2;
            reg_write  = is_jal;
            reg_dst    = is_jal ? 2'd2 : 2'd0;
            mem_to_reg = is_jal ? 2'd2 : 2'd0;
            nxt        = s_if;
          end else if (op == HALT_OP) nxt = s_halt;
          else if (!legal) begin
            illegal  = 1'b1;
            pc_write = 1'b1;
            nxt      = s_if;
          end else nxt = s_exe;
        s_exe: begin
          alu_src_a = src_a_dec;
          alu_src_b = src_b_dec;
          alu_ctrl  = alu_dec;
          if (is_beq || is_bne) begin
            pc_write = 1'b1;
            pc_src   = {1'b0, taken};
            nxt      = s_if;
          end else nxt = (is_lw || is_sw) ? s_mem : s_wb;
        end
        s_mem:
          if (is_lw) begin
            mem_read = 1'b1;
            nxt      = s_wb;
          end else begin
            mem_write = 1'b1;
            pc_write  = 1'b1;
            nxt       = s_if;
          end
        s_wb: begin
          reg_write  = 1'b1;
          reg_dst    = r_type ? 2'd1 : 2'd0;
          mem_to_reg = is_lw ? 2'd1 : 2'd0;
          alu_src_a  = src_a_dec;
          alu_src_b  = src_b_dec;
          alu_ctrl   = alu_dec;
          pc_write   = 1'b1;
          nxt        = s_if;
        end
        s_halt: halted = 1'b1;
        default: nxt = s_if;
      endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed instruction sequences with a per-cycle expected-control scoreboard.
module tb_multicycle_ctrl;
  typedef struct packed {
    logic [2:0]  st;
    logic        irw, pcw;
    logic [1:0]  pcs, rd;
    logic        rw, asa;
    logic [1:0]  asb;
    logic [3:0]  alu;
    logic        mr, mw;
    logic [1:0]  m2r;
    logic        ill, hlt;
    logic [31:0] cnt;
  } ctl_t;
  logic clk = 1'b0, reset_n;
  logic [5:0] op, funct;
  logic zero;
  logic ir_write, pc_write, reg_write, alu_src_a, mem_read, mem_write, illegal, halted;
  logic [1:0] pc_src, reg_dst, alu_src_b, mem_to_reg;
  logic [3:0] alu_ctrl;
  logic [2:0] state;
  logic [31:0] instr_count;
  ctl_t q[$];
  string nq[$];
  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_cnt = 0;
  ctl_t e;
  multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .state(state),
    .illegal(illegal), .halted(halted), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input ctl_t x);
    ctl_t a;
    a = {state, ir_write, pc_write, pc_src, reg_dst, reg_write, alu_src_a, alu_src_b,
         alu_ctrl, mem_read, mem_write, mem_to_reg, illegal, halted, instr_count};
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got state=%0d ctl=%h cnt=%0d, expected state=%0d ctl=%h cnt=%0d",
               name, a.st, a[54:32], a.cnt, x.st, x[54:32], x.cnt);
    end
  endtask
  always @(negedge clk)
    if (q.size() > 0) chk(nq.pop_front(), q.pop_front());
  function automatic ctl_t z(input logic [2:0] s);
    ctl_t r;
    r = '0;
    r.st = s;
    return r;
  endfunction
  task automatic push(input string name, input ctl_t x);
    x.cnt = exp_cnt;
    q.push_back(x);
    nq.push_back(name);
  endtask
  task automatic step(input string name, input ctl_t x);
    push(name, x);
    @(posedge clk);
    #1;
    if (x.pcw) exp_cnt++;
  endtask
  task automatic set_in(input logic [5:0] o, input logic [5:0] f, input logic zf);
    op = o;
    funct = f;
    zero = zf;
  endtask
  task automatic fetch(input string name);
    e = z(0); e.irw = 1; step({name, "_if"}, e);
    step({name, "_id"}, z(1));
  endtask
  task automatic r_instr(input string name, input logic [5:0] f, input logic [3:0] alu);
    set_in(6'b000000, f, 1'b0);
    fetch(name);
    e = z(2); e.alu = alu; e.asa = (f == 6'b000000); step({name, "_exe"}, e);
    e.st = 3'd4; e.rw = 1; e.rd = 1; e.pcw = 1; step({name, "_wb"}, e);
  endtask
  task automatic imm_instr(input string name, input logic [5:0] o, input logic [1:0] asb, input logic [3:0] alu);
    set_in(o, 6'b010101, 1'b0);
    fetch(name);
    e = z(2); e.asb = asb; e.alu = alu; step({name, "_exe"}, e);
    e.st = 3'd4; e.rw = 1; e.pcw = 1; step({name, "_wb"}, e);
  endtask
  task automatic br_instr(input string name, input logic [5:0] o, input logic zf, input logic [1:0] pcs);
    set_in(o, 6'b000000, zf);
    fetch(name);
    e = z(2); e.alu = 1; e.pcw = 1; e.pcs = pcs; step({name, "_exe"}, e);
  endtask
  initial begin
    reset_n = 1'b0;
    set_in(6'b000000, 6'b100000, 1'b0);
    @(posedge clk);
    #1;
    step("reset_hold", z(0));
    reset_n = 1'b1;
    r_instr("add", 6'b100000, 4'd0);
    r_instr("sub", 6'b100010, 4'd1);
    r_instr("and", 6'b100100, 4'd2);
    r_instr("or", 6'b100101, 4'd3);
    r_instr("slt", 6'b101010, 4'd4);
    r_instr("sll", 6'b000000, 4'd5);
    imm_instr("addi", 6'b001000, 2'd1, 4'd0);
    imm_instr("slti", 6'b001010, 2'd1, 4'd4);
    imm_instr("ori", 6'b001101, 2'd2, 4'd3);
    set_in(6'b100011, 6'b000000, 1'b0);
    fetch("lw");
    e = z(2); e.asb = 1; step("lw_exe", e);
    e = z(3); e.mr = 1; step("lw_mem", e);
    e = z(4); e.rw = 1; e.m2r = 1; e.asb = 1; e.pcw = 1; step("lw_wb", e);
    set_in(6'b101011, 6'b000000, 1'b0);
    fetch("sw");
    e = z(2); e.asb = 1; step("sw_exe", e);
    e = z(3); e.mw = 1; e.pcw = 1; step("sw_mem", e);
    br_instr("beq_t", 6'b000100, 1'b1, 2'd1);
    br_instr("beq_nt", 6'b000100, 1'b0, 2'd0);
    br_instr("bne_t", 6'b000101, 1'b0, 2'd1);
    br_instr("bne_nt", 6'b000101, 1'b1, 2'd0);
    set_in(6'b000011, 6'b000000, 1'b0);
    e = z(0); e.irw = 1; step("jal_if", e);
    e = z(1); e.rw = 1; e.rd = 2; e.m2r = 2; e.pcw = 1; e.pcs = 2; step("jal_id", e);
    set_in(6'b000010, 6'b000000, 1'b0);
    e = z(0); e.irw = 1; step("j_if", e);
    e = z(1); e.pcw = 1; e.pcs = 2; step("j_id", e);
    set_in(6'b010000, 6'b000000, 1'b0);
    e = z(0); e.irw = 1; step("ill_op_if", e);
    e = z(1); e.ill = 1; e.pcw = 1; step("ill_op_id", e);
    set_in(6'b000000, 6'b111000, 1'b0);
    e = z(0); e.irw = 1; step("ill_fn_if", e);
    e = z(1); e.ill = 1; e.pcw = 1; step("ill_fn_id", e);
    set_in(6'b111111, 6'b000000, 1'b0);
    fetch("halt");
    for (int i = 0; i < 20; i++) begin
      e = z(5); e.hlt = 1; step("halt_hold", e);
    end
    reset_n = 1'b0;
    exp_cnt = 0;
    step("halt_reset", z(0));
    reset_n = 1'b1;
    set_in(6'b001000, 6'b000000, 1'b0);
    fetch("addi_rst");
    e = z(2); e.asb = 1; push("addi_rst_exe", e);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_exe", z(0));
    @(posedge clk);
    #1;
    step("async_reset_hold", z(0));
    reset_n = 1'b1;
    r_instr("add_after", 6'b100000, 4'd0);
    e = z(0); e.irw = 1; step("final_if", e);
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
